digilock_code_checker: RTL and testbench
========================================

// Module: digilock_code_checker
// PURPOSE
//   Consumes the registered BCD digit and key-pressed flag from the keypad encoder.
//   Collects N_DIGITS keypresses, compares them to the stored code, and drives the
//   lock-open and alarm outputs.
//   Also counts failed attempts, applies a lockout after MAX_TRIES failures, and
//   clears a partial entry after an idle timeout.
// PARAMETERS
//   N_DIGITS        4        digits per code (1..8)
//   SENHA           16'h1234 reset code, 4*N_DIGITS bits; first digit entered = MS nibble
//   MAX_TRIES       3        consecutive failures that trigger LOCKOUT (>=1)
//   OPEN_CYCLES     1000     clocks aberto stays high
//   LOCKOUT_CYCLES  5000     clocks bloqueado stays high
//   TIMEOUT_CYCLES  3000     idle clocks before a partial entry is discarded
// PORTS
//   clk             in   1    system clock, rising edge
//   rst_n           in   1    asynchronous reset, active low
//   BCD             in   4    digit from encoder, valid while tecla_acionada=1
//   tecla_acionada  in   1    level, high while a key is held
//   aberto          out  1    lock open
//   bloqueado       out  1    lockout active
//   erro            out  1    1-clock pulse on wrong code
//   digitos         out  4    digits captured in the current entry (0..N_DIGITS)
//   tentativas      out  4    consecutive failed attempts so far
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=ENTRY; outputs all 0; buffer, counters and tecla_q all 0.
//     - Under DIGILOCK_PROG_EN, the code register loads SENHA.
//   Edge detect:
//     - press = tecla_acionada & ~tecla_q, where tecla_q is tecla_acionada registered.
//     - A held key yields exactly one press.
//     - A press with BCD>9 is ignored (no count change, but it resets the idle timer).
//   ENTRY:
//     - A valid press shifts BCD into the LS nibble of the buffer and increments digitos.
//     - The capturing edge of digit N_DIGITS moves the FSM to CHECK.
//     - Idle timer clears on every press. It runs only while 0 < digitos < N_DIGITS.
//     - When the timer reaches TIMEOUT_CYCLES: buffer and digitos -> 0; tentativas unchanged.
//   CHECK (exactly 1 cycle; presses ignored; digitos -> 0 on exit):
//     - Match: go to OPEN; tentativas -> 0.
//     - Mismatch: erro=1 for the exit cycle; tentativas+1.
//       If the new value == MAX_TRIES, go to LOCKOUT, otherwise go to ENTRY.
//   OPEN:
//     - aberto=1 for exactly OPEN_CYCLES clocks, then ENTRY.
//     - Presses are ignored (edge detect still runs, so a held key is not re-seen later).
//   LOCKOUT:
//     - bloqueado=1 for exactly LOCKOUT_CYCLES clocks; presses ignored.
//     - Exit goes to ENTRY with tentativas -> 0.
//   Latency:
//     - Last-digit press sampled at edge E0 -> CHECK after E0.
//     - aberto, erro or bloqueado are asserted after E1.
//   Outputs:
//     - All outputs are decoded from registered state and counters; no input-to-output
//       combinational path.
//   Simultaneous events:
//     - A timeout on the same edge as a valid press: the press wins (digit captured,
//       timer cleared).
//   Reset mid-operation:
//     - Aborts any state immediately; a partial code is never retained.
// CONFIGURATION
//   DIGILOCK_PROG_EN defined:
//     - Adds input port `programar` (1 bit). The code is held in a register.
//     - In OPEN, programar=1 moves to PROG, with aberto held at 1.
//     - In PROG, N_DIGITS valid presses are written to the code register, then ENTRY.
//     - Timeout in PROG returns to ENTRY with the code unchanged.
//   DIGILOCK_PROG_EN undefined:
//     - No `programar` port, no PROG state; the code is the constant SENHA.
// TESTING   (bench params: OPEN_CYCLES=8, LOCKOUT_CYCLES=16, TIMEOUT_CYCLES=50, 10 ns clk)
//   1. Press 1,2,3,4 (each held 3 clk, 2 clk gap)
//      -> aberto=1 two clocks after the '4' press, for 8 clocks; tentativas=0.
//   2. Press 1,2,3,5 -> erro pulses 1 clock; tentativas=1; aberto stays 0; digitos=0.
//   3. Three wrong codes in a row
//      -> bloqueado=1 for 16 clocks; presses meanwhile leave digitos=0;
//         afterwards 1,2,3,4 opens.
//   4. Press 1,2 then idle 50 clocks -> digitos returns 0; then 1,2,3,4 opens.
//   5. Hold '7' for 20 clocks -> digitos increments once.
//      rst_n=0 mid-entry -> all outputs 0 asynchronously.
//   6. [DIGILOCK_PROG_EN] Open, assert programar, press 9,8,7,6
//      -> 1,2,3,4 now gives erro; 9,8,7,6 gives aberto.

Source files
------------

// File: rtl/digilock_code_checker.sv
// Keypad code checker: collects N_DIGITS BCD presses, compares them against the stored code,
// drives open/alarm/lockout outputs. Optional code reprogramming from OPEN under DIGILOCK_PROG_EN.
module digilock_code_checker #(
  parameter int                      N_DIGITS       = 4,
  parameter logic [4*N_DIGITS-1:0]   SENHA          = 16'h1234,
  parameter int                      MAX_TRIES      = 3,
  parameter int                      OPEN_CYCLES    = 1000,
  parameter int                      LOCKOUT_CYCLES = 5000,
  parameter int                      TIMEOUT_CYCLES = 3000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] BCD,
  input  logic       tecla_acionada,
`ifdef DIGILOCK_PROG_EN
  input  logic       programar,
`endif
  output logic       aberto,
  output logic       bloqueado,
  output logic       erro,
  output logic [3:0] digitos,
  output logic [3:0] tentativas
);

  localparam int BW   = 4 * N_DIGITS;
  localparam int MAXC = (OPEN_CYCLES > LOCKOUT_CYCLES)
                        ? ((OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES)
                        : ((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES);
  localparam int TW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT
`ifdef DIGILOCK_PROG_EN
    , PROG
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      tent_q, tent_d;
  logic [3:0]      tent_inc;
  logic [TW-1:0]   timer_q, timer_d;
  logic            erro_q, erro_d;
  logic            tecla_q;
  logic            press;
  logic            digit_ok;

`ifdef DIGILOCK_PROG_EN
  logic [BW-1:0]   code_val, code_d;
`else
  localparam logic [BW-1:0] code_val = SENHA;
`endif

  assign press    = tecla_acionada & ~tecla_q;
  assign digit_ok = press && (BCD <= 4'd9);
  assign tent_inc = tent_q + 4'd1;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tent_d  = tent_q;
    timer_d = timer_q;
    erro_d  = 1'b0;
`ifdef DIGILOCK_PROG_EN
    code_d  = code_val;
`endif
    unique case (state_q)
      ENTRY: begin
        if (press) begin
          // Any press, even an invalid digit, restarts the idle window and beats a timeout.
          timer_d = '0;
          if (digit_ok) begin
            buf_d = (buf_q << 4) | BW'(BCD);
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(N_DIGITS - 1)) state_d = CHECK;
          end
        end else if (cnt_q != '0) begin
          if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            buf_d   = '0;
            cnt_d   = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      CHECK: begin
        buf_d   = '0;
        cnt_d   = '0;
        timer_d = '0;
        if (buf_q == code_val) begin
          tent_d  = '0;
          state_d = OPEN;
        end else begin
          erro_d  = 1'b1;
          tent_d  = tent_inc;
          state_d = (tent_inc == 4'(MAX_TRIES)) ? LOCKOUT : ENTRY;
        end
      end
      OPEN: begin
`ifdef DIGILOCK_PROG_EN
        if (programar) begin
          timer_d = '0;
          state_d = PROG;
        end else
`endif
        if (timer_q == TW'(OPEN_CYCLES - 1)) begin
          timer_d = '0;
          state_d = ENTRY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
          timer_d = '0;
          tent_d  = '0;
          state_d = ENTRY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef DIGILOCK_PROG_EN
      PROG: begin
        if (press) begin
          timer_d = '0;
          if (digit_ok) begin
            buf_d = (buf_q << 4) | BW'(BCD);
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(N_DIGITS - 1)) begin
              code_d  = (buf_q << 4) | BW'(BCD);
              buf_d   = '0;
              cnt_d   = '0;
              state_d = ENTRY;
            end
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          buf_d   = '0;
          cnt_d   = '0;
          timer_d = '0;
          state_d = ENTRY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      default: state_d = ENTRY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTRY;
      buf_q   <= '0;
      cnt_q   <= '0;
      tent_q  <= '0;
      timer_q <= '0;
      erro_q  <= 1'b0;
      tecla_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      tent_q  <= tent_d;
      timer_q <= timer_d;
      erro_q  <= erro_d;
      tecla_q <= tecla_acionada;
    end
  end

`ifdef DIGILOCK_PROG_EN
  // NOTE: the code register is reset to SENHA so the lock is always usable after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) code_val <= SENHA;
    else        code_val <= code_d;
  end
`endif

`ifdef DIGILOCK_PROG_EN
  assign aberto = (state_q == OPEN) || (state_q == PROG);
`else
  assign aberto = (state_q == OPEN);
`endif
  assign bloqueado  = (state_q == LOCKOUT);
  assign erro       = erro_q;
  assign digitos    = cnt_q;
  assign tentativas = tent_q;

endmodule

// File: tb/tb_digilock_code_checker.sv
// Directed bench for digilock_code_checker: table of code entries plus hand-written
// sequences for timing, lockout, timeout, held keys, async reset and (optionally) reprogramming.
module tb_digilock_code_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] bcd;
  logic       tecla;
  logic       aberto, bloqueado, erro;
  logic [3:0] digitos, tentativas;
`ifdef DIGILOCK_PROG_EN
  logic       programar = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digilock_code_checker #(
    .N_DIGITS(4), .SENHA(16'h1234), .MAX_TRIES(3),
    .OPEN_CYCLES(8), .LOCKOUT_CYCLES(16), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .BCD(bcd),
    .tecla_acionada(tecla),
`ifdef DIGILOCK_PROG_EN
    .programar(programar),
`endif
    .aberto(aberto),
    .bloqueado(bloqueado),
    .erro(erro),
    .digitos(digitos),
    .tentativas(tentativas)
  );

  typedef struct {
    logic [15:0] code;
    logic        exp_open;
    logic        exp_erro;
    logic        exp_lock;
    logic [3:0]  exp_tent;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d);
    bcd   = d;
    tecla = 1'b1;
    repeat (3) tick();
    tecla = 1'b0;
    repeat (2) tick();
  endtask

  // Enters a full code; returns one sample after the cycle following CHECK (key released).
  task automatic enter_code(input logic [15:0] code);
    for (int k = 0; k < 3; k++) press_key(code[15 - 4*k -: 4]);
    bcd   = code[3:0];
    tecla = 1'b1;
    tick();
    tick();
    tecla = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && (aberto || bloqueado); n++) tick();
    check("wait_idle", int'(aberto | bloqueado), 0);
    tick();
  endtask

  vec_t vec[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int max_d;

    vec[0] = '{16'h1235, 1'b0, 1'b1, 1'b0, 4'd1};
    vec[1] = '{16'h1234, 1'b1, 1'b0, 1'b0, 4'd0};
    vec[2] = '{16'h9999, 1'b0, 1'b1, 1'b0, 4'd1};
    vec[3] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'd2};
    vec[4] = '{16'h1234, 1'b1, 1'b0, 1'b0, 4'd0};
    vec[5] = '{16'h4321, 1'b0, 1'b1, 1'b0, 4'd1};
    vec[6] = '{16'h2341, 1'b0, 1'b1, 1'b0, 4'd2};
    vec[7] = '{16'h5678, 1'b0, 1'b1, 1'b1, 4'd3};

    rst_n = 1'b0;
    tecla = 1'b0;
    bcd   = 4'd0;
    repeat (2) tick();
    check("rst_aberto", int'(aberto), 0);
    check("rst_bloqueado", int'(bloqueado), 0);
    check("rst_erro", int'(erro), 0);
    check("rst_digitos", int'(digitos), 0);
    check("rst_tentativas", int'(tentativas), 0);
    rst_n = 1'b1;
    tick();

    // Correct code: open two clocks after the last press, held for exactly 8 clocks.
    press_key(4'd1);
    press_key(4'd2);
    press_key(4'd3);
    check("t1_digitos3", int'(digitos), 3);
    bcd   = 4'd4;
    tecla = 1'b1;
    tick();
    check("t1_check_digitos", int'(digitos), 4);
    check("t1_not_open_yet", int'(aberto), 0);
    tick();
    check("t1_open", int'(aberto), 1);
    check("t1_tent", int'(tentativas), 0);
    n = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) tecla = 1'b0;
      tick();
      n += int'(aberto);
    end
    check("t1_open_len", n, 8);

    // Table of entries: response one cycle after CHECK, erro is a single-clock pulse.
    for (int i = 0; i < 8; i++) begin
      enter_code(vec[i].code);
      check($sformatf("v%0d_aberto", i), int'(aberto), int'(vec[i].exp_open));
      check($sformatf("v%0d_erro", i), int'(erro), int'(vec[i].exp_erro));
      check($sformatf("v%0d_bloq", i), int'(bloqueado), int'(vec[i].exp_lock));
      check($sformatf("v%0d_tent", i), int'(tentativas), int'(vec[i].exp_tent));
      check($sformatf("v%0d_digitos", i), int'(digitos), 0);
      tick();
      check($sformatf("v%0d_erro_off", i), int'(erro), 0);
      wait_idle();
    end
    check("after_lock_tent", int'(tentativas), 0);

    // Three wrong codes: lockout for 16 clocks, presses ignored, then correct code opens.
    press_key(4'd9); press_key(4'd9); press_key(4'd9); press_key(4'd9);
    press_key(4'd9); press_key(4'd9); press_key(4'd9); press_key(4'd9);
    check("t3_tent2", int'(tentativas), 2);
    enter_code(16'h9999);
    check("t3_bloq", int'(bloqueado), 1);
    check("t3_tent3", int'(tentativas), 3);
    n = 1;
    max_d = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 3) begin bcd = 4'd5; tecla = 1'b1; end
      if (c == 6) tecla = 1'b0;
      tick();
      n += int'(bloqueado);
      if (int'(digitos) > max_d) max_d = int'(digitos);
    end
    check("t3_bloq_len", n, 16);
    check("t3_digitos_locked", max_d, 0);
    check("t3_tent_cleared", int'(tentativas), 0);
    enter_code(16'h1234);
    check("t3_open_after", int'(aberto), 1);
    wait_idle();

    // Partial entry discarded after the idle timeout, attempt count untouched.
    enter_code(16'h1111);
    tick();
    press_key(4'd1);
    press_key(4'd2);
    check("t4_digitos2", int'(digitos), 2);
    repeat (30) tick();
    check("t4_still2", int'(digitos), 2);
    repeat (30) tick();
    check("t4_timed_out", int'(digitos), 0);
    check("t4_tent_kept", int'(tentativas), 1);
    enter_code(16'h1234);
    check("t4_open", int'(aberto), 1);
    wait_idle();

    // Held key counts once; invalid digit ignored; async reset clears everything.
    enter_code(16'h1235);
    tick();
    bcd   = 4'd7;
    tecla = 1'b1;
    repeat (20) tick();
    check("t5_held_once", int'(digitos), 1);
    tecla = 1'b0;
    tick();
    press_key(4'd11);
    check("t5_invalid_ignored", int'(digitos), 1);
    check("t5_tent_pre", int'(tentativas), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_digitos", int'(digitos), 0);
    check("t5_async_tent", int'(tentativas), 0);
    check("t5_async_out", int'({aberto, bloqueado, erro}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    enter_code(16'h1234);
    check("t5_open_after_rst", int'(aberto), 1);
    wait_idle();

`ifdef DIGILOCK_PROG_EN
    // Reprogram the code from OPEN and verify old/new codes.
    enter_code(16'h1234);
    check("t6_open", int'(aberto), 1);
    programar = 1'b1;
    tick();
    programar = 1'b0;
    press_key(4'd9); press_key(4'd8); press_key(4'd7);
    check("t6_prog_aberto", int'(aberto), 1);
    press_key(4'd6);
    check("t6_prog_done", int'(aberto), 0);
    check("t6_prog_digitos", int'(digitos), 0);
    enter_code(16'h1234);
    check("t6_old_erro", int'(erro), 1);
    check("t6_old_closed", int'(aberto), 0);
    tick();
    enter_code(16'h9876);
    check("t6_new_open", int'(aberto), 1);
    wait_idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
